// File: rtl/logo_motion.sv
// logo_motion: bouncing-logo position generator for a raster display.
//   Counts frames through a blanking-time strobe (x_px==0, y_px==V_ACTIVE).
//   Every FRAME_DIV frames it moves the logo top-left corner STEP pixels per
//   axis. On hitting a wall it clamps to that wall and reverses that axis.
// Ports:
//   clk        pixel clock (one pixel per cycle)
//   clr        synchronous active-high reset
//   pause      (LOGO_PAUSE_EN only) freezes frame counting and motion
//   x_px/y_px  current scan position
//   x_logo/y_logo  logo top-left corner
//   dir_x/dir_y    1 = right/down, 0 = left/up
//   bounce     one-cycle pulse when either axis hit a wall on an update
//   corner     one-cycle pulse when both axes hit on the same update
// Build option: define LOGO_PAUSE_EN to add the pause input.
module logo_motion #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int width_logo  = 80,
   parameter int height_logo = 96,
   parameter int STEP        = 1,
   parameter int FRAME_DIV   = 1,
   parameter int X_INIT      = 0,
   parameter int Y_INIT      = 0
) (
   input  logic       clk,
   input  logic       clr,
`ifdef LOGO_PAUSE_EN
   input  logic       pause,
`endif
   input  logic [9:0] x_px,
   input  logic [9:0] y_px,
   output logic [9:0] x_logo,
   output logic [9:0] y_logo,
   output logic       dir_x,
   output logic       dir_y,
   output logic       bounce,
   output logic       corner
);

   localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - width_logo);
   localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - height_logo);
   localparam logic [10:0] STEP_W   = 11'(STEP);
   localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

   typedef enum logic [1:0] {S_WAIT, S_EVAL, S_COMMIT} state_t;

   state_t     state_q, state_d;
   logic       cmp_q;
   logic [7:0] fcnt_q, fcnt_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       dx_q, dx_d, dy_q, dy_d;
   logic       bounce_q, bounce_d, corner_q, corner_d;

   logic       cmp_d, strobe, run, accept;
   logic [11:0] nx_pack, ny_pack;

   // One axis step in 11-bit unsigned arithmetic. Returns {hit, dir, pos}.
   // Moving toward a wall clamps to it (never overshoots), so out-of-range
   // initial positions are pulled back into range on the first update.
   function automatic logic [11:0] axis_next(input logic [9:0]  pos,
                                             input logic        dir,
                                             input logic [10:0] lim);
      logic [10:0] p;
      logic [10:0] sum;
      logic        hit;
      logic        d;
      p   = {1'b0, pos};
      sum = p + STEP_W;
      if (dir) begin
         hit = (sum >= lim);
         d   = ~hit;
         p   = hit ? lim : sum;
      end else begin
         hit = (p <= STEP_W);
         d   = hit;
         p   = hit ? 11'd0 : p - STEP_W;
      end
      return {hit, d, p[9:0]};
   endfunction

   // Frame strobe: rising edge of the registered blanking-position compare,
   // so holding the scan at the strobe position yields a single strobe.
   assign cmp_d  = (x_px == 10'd0) && (y_px == 10'(V_ACTIVE));
   assign strobe = cmp_d & ~cmp_q;

`ifdef LOGO_PAUSE_EN
   assign run = ~pause;
`else
   assign run = 1'b1;
`endif

   // Strobes are only counted while idle; EVAL/COMMIT ignore them.
   assign accept  = strobe & run & (state_q == S_WAIT);
   assign nx_pack = axis_next(x_q, dx_q, X_MAX);
   assign ny_pack = axis_next(y_q, dy_q, Y_MAX);

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      x_d      = x_q;
      y_d      = y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      bounce_d = 1'b0;
      corner_d = 1'b0;
      case (state_q)
         S_WAIT: begin
            if (accept) begin
               if (fcnt_q == DIV_LAST) begin
                  fcnt_d  = 8'd0;
                  state_d = S_EVAL;
               end else begin
                  fcnt_d  = fcnt_q + 8'd1;
               end
            end
         end
         S_EVAL: begin
            // New position is registered here so it is visible, with the
            // bounce/corner pulse, throughout the COMMIT cycle.
            x_d      = nx_pack[9:0];
            dx_d     = nx_pack[10];
            y_d      = ny_pack[9:0];
            dy_d     = ny_pack[10];
            bounce_d = nx_pack[11] | ny_pack[11];
            corner_d = nx_pack[11] & ny_pack[11];
            state_d  = S_COMMIT;
         end
         S_COMMIT: state_d = S_WAIT;
         default:  state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= S_WAIT;
         cmp_q    <= 1'b0;
         fcnt_q   <= 8'd0;
         x_q      <= 10'(X_INIT);
         y_q      <= 10'(Y_INIT);
         dx_q     <= 1'b1;
         dy_q     <= 1'b1;
         bounce_q <= 1'b0;
         corner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmp_q    <= cmp_d;
         fcnt_q   <= fcnt_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         bounce_q <= bounce_d;
         corner_q <= corner_d;
      end
   end

   assign x_logo = x_q;
   assign y_logo = y_q;
   assign dir_x  = dx_q;
   assign dir_y  = dy_q;
   assign bounce = bounce_q;
   assign corner = corner_q;

endmodule

// File: tb/tb_logo_motion.sv
// Self-checking bench for logo_motion. Four instances with different
// parameters share the scan inputs; a per-instance reference model advances
// positions on every strobe the bench knows the design accepts.
module tb_logo_motion;

   localparam int N = 4;
   localparam int XI[N] = '{0, 559, 560, 700};
   localparam int YI[N] = '{0, 100, 384, 5};
   localparam int ST[N] = '{1, 1, 1, 7};
   localparam int DV[N] = '{1, 1, 1, 3};
   localparam int LX = 640 - 80;
   localparam int LY = 480 - 96;

   logic       clk = 1'b0;
   logic       clr;
   logic [9:0] x_px, y_px;
   logic [9:0] xl[N], yl[N];
   logic       dxo[N], dyo[N], bo[N], co[N];
`ifdef LOGO_PAUSE_EN
   logic       pause = 1'b0;
`endif
   bit         paused = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int mx[N], my[N], mdx[N], mdy[N], mcnt[N], eb[N], ec[N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logo_motion #(
         .H_ACTIVE(640), .V_ACTIVE(480), .width_logo(80), .height_logo(96),
         .STEP(ST[g]), .FRAME_DIV(DV[g]), .X_INIT(XI[g]), .Y_INIT(YI[g])
      ) u_dut (
         .clk(clk),
         .clr(clr),
`ifdef LOGO_PAUSE_EN
         .pause(pause),
`endif
         .x_px(x_px),
         .y_px(y_px),
         .x_logo(xl[g]),
         .y_logo(yl[g]),
         .dir_x(dxo[g]),
         .dir_y(dyo[g]),
         .bounce(bo[g]),
         .corner(co[g])
      );
   end

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int idx,
                      input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = XI[i]; my[i] = YI[i]; mdx[i] = 1; mdy[i] = 1;
         mcnt[i] = 0; eb[i] = 0; ec[i] = 0;
      end
   endtask

   // One accepted frame: count it, and every DV frames move each axis
   // toward its current wall, stopping at the wall and turning around.
   task automatic model_frame();
      int hx, hy;
      for (int i = 0; i < N; i++) begin
         eb[i] = 0; ec[i] = 0;
         if (!paused) begin
            mcnt[i]++;
            if (mcnt[i] == DV[i]) begin
               mcnt[i] = 0;
               if (mdx[i] == 1) begin
                  hx = (mx[i] + ST[i] >= LX);
                  mx[i] = hx ? LX : mx[i] + ST[i];
                  if (hx) mdx[i] = 0;
               end else begin
                  hx = (mx[i] <= ST[i]);
                  mx[i] = hx ? 0 : mx[i] - ST[i];
                  if (hx) mdx[i] = 1;
               end
               if (mdy[i] == 1) begin
                  hy = (my[i] + ST[i] >= LY);
                  my[i] = hy ? LY : my[i] + ST[i];
                  if (hy) mdy[i] = 0;
               end else begin
                  hy = (my[i] <= ST[i]);
                  my[i] = hy ? 0 : my[i] - ST[i];
                  if (hy) mdy[i] = 1;
               end
               eb[i] = hx | hy;
               ec[i] = hx & hy;
            end
         end
      end
   endtask

   task automatic noise();
      x_px = 10'($urandom_range(0, 1023));
      y_px = 10'($urandom_range(0, 1023));
      if (x_px == 10'd0 && y_px == 10'd480) x_px = 10'd1;
   endtask

   task automatic check_all(input string tag, input bit with_pulse);
      for (int i = 0; i < N; i++) begin
         chk({tag, "_x"}, i, 32'(xl[i]), mx[i]);
         chk({tag, "_y"}, i, 32'(yl[i]), my[i]);
         chk({tag, "_dx"}, i, 32'(dxo[i]), mdx[i]);
         chk({tag, "_dy"}, i, 32'(dyo[i]), mdy[i]);
         chk({tag, "_bounce"}, i, 32'(bo[i]), with_pulse ? eb[i] : 0);
         chk({tag, "_corner"}, i, 32'(co[i]), with_pulse ? ec[i] : 0);
      end
   endtask

   // Strobe, then check the committed state (with pulse) and the cycle after.
   task automatic do_strobe(input string tag);
      x_px = 10'd0; y_px = 10'd480;
      tick();
      model_frame();
      noise();
      tick();
      check_all(tag, 1'b1);
      noise();
      tick();
      check_all({tag, "_post"}, 1'b0);
   endtask

   initial begin
      clr = 1'b1;
      noise();
      model_reset();
      repeat (3) tick();
      check_all("reset", 1'b0);
      clr = 1'b0;
      noise();
      tick();

      // first update: default, near-right-wall, corner, clamp/divider
      do_strobe("s1");
      chk("r028_x", 0, 32'(xl[0]), 1);
      chk("r028_y", 0, 32'(yl[0]), 1);
      chk("r029_x", 1, 32'(xl[1]), 560);
      chk("r029_dx", 1, 32'(dxo[1]), 0);
      do_strobe("s2");
      chk("r030_x", 2, 32'(xl[2]), 559);
      chk("r030_y", 2, 32'(yl[2]), 383);

      // held strobe position must count as a single frame
      x_px = 10'd0; y_px = 10'd480;
      repeat (640) tick();
      model_frame();
      noise();
      tick();
      check_all("hold", 1'b0);
      chk("r031_x", 3, 32'(xl[3]), 560);

      // a new strobe edge during COMMIT is ignored
      x_px = 10'd0; y_px = 10'd480;
      tick();
      model_frame();
      noise();
      tick();
      check_all("busy_commit", 1'b1);
      x_px = 10'd0; y_px = 10'd480;
      tick();
      noise();
      tick();
      check_all("busy_ignored", 1'b0);

      // clr during EVAL aborts the update
      x_px = 10'd0; y_px = 10'd480;
      tick();
      clr = 1'b1;
      noise();
      tick();
      model_reset();
      check_all("clr_eval", 1'b0);
      clr = 1'b0;
      tick();

      // randomized gaps between strobes
      for (int k = 0; k < 60; k++) begin
         int gap;
         gap = $urandom_range(1, 6);
         for (int j = 0; j < gap; j++) begin
            noise();
            tick();
         end
         do_strobe("rnd");
      end

`ifdef LOGO_PAUSE_EN
      pause = 1'b1;
      paused = 1'b1;
      for (int k = 0; k < 5; k++) do_strobe("paused");
      pause = 1'b0;
      paused = 1'b0;
      noise();
      tick();
      do_strobe("resume");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/logo_motion.md
LOGO_MOTION -- requirements
Module: logo_motion

Interface
REQ-001 SHALL have parameters: H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameters: V_ACTIVE, 480, visible lines per frame.
REQ-003 SHALL have parameters: width_logo, 80, logo width in pixels; height_logo, 96, logo height in lines.
REQ-004 SHALL have parameters: STEP, 1, pixels moved per axis per update (1..15); FRAME_DIV, 1, frames per update (1..255).
REQ-005 SHALL have parameters: X_INIT, 0, reset x_logo; Y_INIT, 0, reset y_logo.
REQ-006 Ports: clk  input  1  system clock, one pixel per cycle.
REQ-007 Ports: clr  input  1  reset, synchronous, active-high.
REQ-008 Ports: x_px  input  10  current scan pixel x; y_px  input  10  current scan pixel y.
REQ-009 Ports: x_logo  output  10  logo top-left x; y_logo  output  10  logo top-left y.
REQ-010 Ports: dir_x  output  1  1=right, 0=left; dir_y  output  1  1=down, 0=up.
REQ-011 Ports: bounce  output  1  one-cycle pulse on any wall hit; corner  output  1  one-cycle pulse when both axes hit in the same update.
REQ-012 Ports (only with LOGO_PAUSE_EN): pause  input  1  freeze motion while high.

Function
REQ-013 Frame strobe SHALL assert for exactly one cycle when (x_px==0 && y_px==V_ACTIVE) is true and was false the previous cycle (edge-detected on registered compare).
REQ-014 Frame counter (8 bit) SHALL increment on each strobe; at FRAME_DIV-1 it wraps to 0 and requests an update on that strobe.
REQ-015 Update SHALL commit x_logo, y_logo, dir_x, dir_y exactly 1 cycle after the strobe cycle; outputs never change outside blanking.
REQ-016 Right move: if x_logo+STEP >= H_ACTIVE-width_logo then x_logo=H_ACTIVE-width_logo, dir_x=0, hit_x; else x_logo+=STEP.
REQ-017 Left move: if x_logo <= STEP then x_logo=0, dir_x=1, hit_x; else x_logo-=STEP.
REQ-018 Y axis SHALL follow REQ-016/017 with V_ACTIVE, height_logo, dir_y, hit_y.
REQ-019 All boundary arithmetic SHALL be 11-bit unsigned; no wrap below 0 or above limit; positions always in [0, H_ACTIVE-width_logo] x [0, V_ACTIVE-height_logo].
REQ-020 bounce SHALL pulse high in the commit cycle iff hit_x or hit_y; corner iff hit_x and hit_y; both low otherwise.
REQ-021 Out-of-range X_INIT/Y_INIT SHALL be clamped into the valid range on first update via REQ-016..018.
REQ-022 Control FSM states: WAIT (await strobe), EVAL (compute next values), COMMIT (register outputs, pulse bounce/corner) -> WAIT; strobe during EVAL/COMMIT SHALL be ignored.

Reset
REQ-023 On clr high at a clk edge: x_logo=X_INIT, y_logo=Y_INIT, dir_x=1, dir_y=1, bounce=0, corner=0, frame counter=0, edge register=0, FSM=WAIT.
REQ-024 clr asserted mid-update (EVAL or COMMIT) SHALL abort the update; reset values win; no bounce pulse.
REQ-025 First strobe after clr deassertion SHALL count as frame 0.

Configuration
REQ-026 Macro LOGO_PAUSE_EN defined: port pause exists; while pause=1 strobes neither advance the frame counter nor move the logo; release resumes from held state.
REQ-027 Macro LOGO_PAUSE_EN undefined: no pause port; motion per REQ-013..022 unconditionally.

Verification
REQ-028 Reset, defaults, one strobe (x_px=0,y_px=480) -> after 2 cycles x_logo=1, y_logo=1, dir_x=1, dir_y=1, bounce=0.
REQ-029 X_INIT=559, Y_INIT=100, one update -> x_logo=560, dir_x=0, bounce pulse 1 cycle, corner=0.
REQ-030 X_INIT=560, Y_INIT=384, one update -> x_logo=560, y_logo=384, dir_x=0, dir_y=0, bounce=1, corner=1; next update -> 559, 383.
REQ-031 FRAME_DIV=3, 6 strobes -> exactly 2 position changes, on strobes 3 and 6; y_px held at 480 for 640 cycles yields one strobe only.
REQ-032 clr asserted in EVAL cycle -> outputs X_INIT/Y_INIT, dir 1/1, no bounce pulse.
REQ-033 LOGO_PAUSE_EN, pause=1 over 5 strobes -> x_logo,y_logo unchanged; pause=0 then 1 strobe -> advance by STEP.
